// File: rtl/ecc_rd_corrector.sv
// Read-path SECDED corrector with a 2-entry output FIFO and optional error statistics.
// Define ECC_ERR_STATS_EN to build the CE/UE counters and first-error capture.
module ecc_rd_corrector #(
  parameter int DATA_WIDTH  = 32,
  parameter int PARITY_BITS = 6,
  parameter int ADDR_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   parity_calc_rd_clk,
  input  logic                   parity_calc_rd_rstn,
  input  logic                   sw_rst_i,
  input  logic                   ecc_en_i,
  input  logic                   in_vld_i,
  output logic                   in_rdy_o,
  input  logic [DATA_WIDTH-1:0]  in_data_i,
  input  logic [PARITY_BITS:0]   in_syn_i,
  input  logic [ADDR_WIDTH-1:0]  in_addr_i,
  output logic                   out_vld_o,
  input  logic                   out_rdy_i,
  output logic [DATA_WIDTH-1:0]  out_data_o,
  output logic                   out_ce_o,
  output logic                   out_ue_o,
  input  logic                   clr_cnt_i,
  output logic [CNT_WIDTH-1:0]   ce_cnt_o,
  output logic [CNT_WIDTH-1:0]   ue_cnt_o,
  output logic                   err_vld_o,
  output logic [ADDR_WIDTH-1:0]  err_addr_o,
  output logic [PARITY_BITS:0]   err_syn_o
);

  localparam int ENTRY_W = DATA_WIDTH + 2;

  logic                   ovl;
  logic [PARITY_BITS-1:0] syn_pos;
  logic                   syn_pow2;
  logic [DATA_WIDTH-1:0]  flip;
  logic [DATA_WIDTH-1:0]  dec_data;
  logic                   dec_ce;
  logic                   dec_ue;
  logic                   push;
  logic                   pop;

  logic [ENTRY_W-1:0]     mem [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             count;

  // Data bits occupy the non-power-of-two Hamming positions in ascending order.
  function automatic logic [DATA_WIDTH-1:0] flip_mask(input logic [PARITY_BITS-1:0] pos);
    logic [DATA_WIDTH-1:0] m;
    int k;
    m = '0;
    k = 0;
    for (int p = 1; p < (1 << PARITY_BITS); p++) begin
      if ((p & (p - 1)) != 0) begin
        if (k < DATA_WIDTH && pos == p[PARITY_BITS-1:0])
          m = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << k;
        k++;
      end
    end
    return m;
  endfunction

  assign ovl      = in_syn_i[0];
  assign syn_pos  = in_syn_i[PARITY_BITS:1];
  assign syn_pow2 = (syn_pos & (syn_pos - 1'b1)) == '0;
  assign flip     = flip_mask(syn_pos);

  always_comb begin
    dec_data = in_data_i;
    dec_ce   = 1'b0;
    dec_ue   = 1'b0;
    if (ecc_en_i) begin
      if (ovl) begin
        if (syn_pow2) begin
          dec_ce = 1'b1;
        end else if (flip != '0) begin
          dec_ce   = 1'b1;
          dec_data = in_data_i ^ flip;
        end else begin
          dec_ue = 1'b1;
        end
      end else if (syn_pos != '0) begin
        dec_ue = 1'b1;
      end
    end
  end

  assign push      = in_vld_i & in_rdy_o;
  assign pop       = out_vld_o & out_rdy_i;
  assign in_rdy_o  = (count != 2'd2);
  assign out_vld_o = (count != 2'd0);
  assign out_data_o = mem[rd_ptr][DATA_WIDTH-1:0];
  assign out_ce_o   = mem[rd_ptr][DATA_WIDTH];
  assign out_ue_o   = mem[rd_ptr][DATA_WIDTH+1];

  // Entries are cleared on reset so the idle head reads as all zeros.
  always_ff @(posedge parity_calc_rd_clk or negedge parity_calc_rd_rstn) begin
    if (!parity_calc_rd_rstn) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (sw_rst_i) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {dec_ue, dec_ce, dec_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef ECC_ERR_STATS_EN
  // Clear takes priority over a coincident increment or capture.
  always_ff @(posedge parity_calc_rd_clk or negedge parity_calc_rd_rstn) begin
    if (!parity_calc_rd_rstn) begin
      ce_cnt_o   <= '0;
      ue_cnt_o   <= '0;
      err_vld_o  <= 1'b0;
      err_addr_o <= '0;
      err_syn_o  <= '0;
    end else if (sw_rst_i || clr_cnt_i) begin
      ce_cnt_o   <= '0;
      ue_cnt_o   <= '0;
      err_vld_o  <= 1'b0;
      err_addr_o <= '0;
      err_syn_o  <= '0;
    end else if (push) begin
      if (dec_ce && !(&ce_cnt_o)) ce_cnt_o <= ce_cnt_o + 1'b1;
      if (dec_ue && !(&ue_cnt_o)) ue_cnt_o <= ue_cnt_o + 1'b1;
      if ((dec_ce || dec_ue) && !err_vld_o) begin
        err_vld_o  <= 1'b1;
        err_addr_o <= in_addr_i;
        err_syn_o  <= in_syn_i;
      end
    end
  end
`else
  logic stats_unused;
  assign stats_unused = ^{clr_cnt_i, in_addr_i};
  assign ce_cnt_o   = '0;
  assign ue_cnt_o   = '0;
  assign err_vld_o  = 1'b0;
  assign err_addr_o = '0;
  assign err_syn_o  = '0;
`endif

endmodule

// File: tb/tb_ecc_rd_corrector.sv
// Directed bench for ecc_rd_corrector; counters built 2 bits wide to reach saturation quickly.
module tb_ecc_rd_corrector;

`ifdef ECC_ERR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sw_rst = 1'b0;
  logic        ecc_en = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [31:0] in_data = '0;
  logic [6:0]  in_syn = '0;
  logic [31:0] in_addr = '0;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [31:0] out_data;
  logic        out_ce;
  logic        out_ue;
  logic        clr_cnt = 1'b0;
  logic [1:0]  ce_cnt;
  logic [1:0]  ue_cnt;
  logic        err_vld;
  logic [31:0] err_addr;
  logic [6:0]  err_syn;

  int checks = 0;
  int errors = 0;

  ecc_rd_corrector #(.DATA_WIDTH(32), .PARITY_BITS(6), .ADDR_WIDTH(32), .CNT_WIDTH(2)) dut (
    .parity_calc_rd_clk(clk), .parity_calc_rd_rstn(rstn), .sw_rst_i(sw_rst), .ecc_en_i(ecc_en),
    .in_vld_i(in_vld), .in_rdy_o(in_rdy), .in_data_i(in_data), .in_syn_i(in_syn),
    .in_addr_i(in_addr), .out_vld_o(out_vld), .out_rdy_i(out_rdy), .out_data_o(out_data),
    .out_ce_o(out_ce), .out_ue_o(out_ue), .clr_cnt_i(clr_cnt), .ce_cnt_o(ce_cnt),
    .ue_cnt_o(ue_cnt), .err_vld_o(err_vld), .err_addr_o(err_addr), .err_syn_o(err_syn)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [6:0] s, input logic [31:0] a);
    in_vld = 1'b1; in_data = d; in_syn = s; in_addr = a;
    tick();
    in_vld = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_rdy: got %b expected 1", in_rdy); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_vld: got %b expected 0", out_vld); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_out_data: got %h expected 0", out_data); end
    checks++; if ({out_ce, out_ue, err_vld} !== 3'b000) begin errors++; $display("[TB] FAIL rst_flags: got %b expected 000", {out_ce, out_ue, err_vld}); end
    checks++; if ({ce_cnt, ue_cnt} !== 4'h0) begin errors++; $display("[TB] FAIL rst_counts: got %h expected 0", {ce_cnt, ue_cnt}); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_clean;
    ecc_en = 1'b1; out_rdy = 1'b1;
    drive_beat(32'hA5A5A5A5, 7'h00, 32'h100);
    checks++; if (out_vld !== 1'b1) begin errors++; $display("[TB] FAIL t1_vld: got %b expected 1", out_vld); end
    checks++; if (out_data !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL t1_data: got %h expected a5a5a5a5", out_data); end
    checks++; if ({out_ce, out_ue} !== 2'b00) begin errors++; $display("[TB] FAIL t1_flags: got %b expected 00", {out_ce, out_ue}); end
    tick();
    checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL t1_popped: got %b expected 0", out_vld); end
  endtask

  task automatic test_ce;
    drive_beat(32'h00000001, 7'h07, 32'h1000);
    checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL t2a_data: got %h expected 0", out_data); end
    checks++; if ({out_ce, out_ue} !== 2'b10) begin errors++; $display("[TB] FAIL t2a_flags: got %b expected 10", {out_ce, out_ue}); end
    checks++; if (ce_cnt !== (STATS ? 2'd1 : 2'd0)) begin errors++; $display("[TB] FAIL t2a_ce_cnt: got %0d expected %0d", ce_cnt, STATS ? 1 : 0); end
    checks++; if (err_vld !== STATS) begin errors++; $display("[TB] FAIL t2a_err_vld: got %b expected %b", err_vld, STATS); end
    checks++; if (err_addr !== (STATS ? 32'h1000 : 32'h0)) begin errors++; $display("[TB] FAIL t2a_err_addr: got %h expected %h", err_addr, STATS ? 32'h1000 : 32'h0); end
    checks++; if (err_syn !== (STATS ? 7'h07 : 7'h00)) begin errors++; $display("[TB] FAIL t2a_err_syn: got %h expected %h", err_syn, STATS ? 7'h07 : 7'h00); end
    tick();
    drive_beat(32'h80000000, 7'h4D, 32'h2000);
    checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL t2b_data: got %h expected 0", out_data); end
    checks++; if (out_ce !== 1'b1) begin errors++; $display("[TB] FAIL t2b_ce: got %b expected 1", out_ce); end
    checks++; if (ce_cnt !== (STATS ? 2'd2 : 2'd0)) begin errors++; $display("[TB] FAIL t2b_ce_cnt: got %0d expected %0d", ce_cnt, STATS ? 2 : 0); end
    checks++; if (err_addr !== (STATS ? 32'h1000 : 32'h0)) begin errors++; $display("[TB] FAIL t2b_err_addr: got %h expected %h", err_addr, STATS ? 32'h1000 : 32'h0); end
    tick();
  endtask

  task automatic test_ue;
    logic [31:0] d [4] = '{32'h12345678, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0F0F0F0F};
    logic [6:0]  s [4] = '{7'h06, 7'h7F, 7'h4F, 7'h7E};
    logic [1:0]  n [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    for (int i = 0; i < 4; i++) begin
      drive_beat(d[i], s[i], 32'h3000 + 32'(i));
      checks++; if (out_data !== d[i]) begin errors++; $display("[TB] FAIL t3_data[%0d]: got %h expected %h", i, out_data, d[i]); end
      checks++; if ({out_ce, out_ue} !== 2'b01) begin errors++; $display("[TB] FAIL t3_flags[%0d]: got %b expected 01", i, {out_ce, out_ue}); end
      checks++; if (ue_cnt !== (STATS ? n[i] : 2'd0)) begin errors++; $display("[TB] FAIL t3_ue_cnt[%0d]: got %0d expected %0d", i, ue_cnt, STATS ? n[i] : 2'd0); end
      tick();
    end
    checks++; if (err_addr !== (STATS ? 32'h1000 : 32'h0)) begin errors++; $display("[TB] FAIL t3_err_addr: got %h expected %h", err_addr, STATS ? 32'h1000 : 32'h0); end
    checks++; if (ce_cnt !== (STATS ? 2'd2 : 2'd0)) begin errors++; $display("[TB] FAIL t3_ce_cnt: got %0d expected %0d", ce_cnt, STATS ? 2 : 0); end
  endtask

  task automatic test_saturation;
    logic [31:0] d [5] = '{32'h55, 32'h55, 32'h0, 32'hFFFFFFFF, 32'h0};
    logic [6:0]  s [5] = '{7'h01, 7'h09, 7'h0B, 7'h23, 7'h1F};
    logic [31:0] e [5] = '{32'h55, 32'h55, 32'h2, 32'hFFFFF7FF, 32'h400};
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checks++; if ({ce_cnt, ue_cnt, err_vld} !== 5'b0) begin errors++; $display("[TB] FAIL t5_clr: got %b expected 0", {ce_cnt, ue_cnt, err_vld}); end
    for (int i = 0; i < 5; i++) begin
      drive_beat(d[i], s[i], 32'h4000 + 32'(i * 4));
      checks++; if (out_data !== e[i]) begin errors++; $display("[TB] FAIL t5_data[%0d]: got %h expected %h", i, out_data, e[i]); end
      checks++; if ({out_ce, out_ue} !== 2'b10) begin errors++; $display("[TB] FAIL t5_flags[%0d]: got %b expected 10", i, {out_ce, out_ue}); end
      tick();
    end
    checks++; if (ce_cnt !== (STATS ? 2'd3 : 2'd0)) begin errors++; $display("[TB] FAIL t5_sat: got %0d expected %0d", ce_cnt, STATS ? 3 : 0); end
    checks++; if (err_addr !== (STATS ? 32'h4000 : 32'h0)) begin errors++; $display("[TB] FAIL t5_err_addr: got %h expected %h", err_addr, STATS ? 32'h4000 : 32'h0); end
    checks++; if (err_syn !== (STATS ? 7'h01 : 7'h00)) begin errors++; $display("[TB] FAIL t5_err_syn: got %h expected %h", err_syn, STATS ? 7'h01 : 7'h00); end
    clr_cnt = 1'b1;
    drive_beat(32'h00000001, 7'h07, 32'h5000);
    clr_cnt = 1'b0;
    checks++; if (ce_cnt !== 2'd0) begin errors++; $display("[TB] FAIL t5_clr_wins: got %0d expected 0", ce_cnt); end
    checks++; if (err_vld !== 1'b0) begin errors++; $display("[TB] FAIL t5_clr_err_vld: got %b expected 0", err_vld); end
    checks++; if (out_data !== 32'h0 || out_ce !== 1'b1) begin errors++; $display("[TB] FAIL t5_clr_beat: got %h/%b expected 0/1", out_data, out_ce); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] rx [3] = '{32'h0, 32'h0, 32'h0};
    logic [31:0] ex [3] = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
    int got = 0;
    logic acc;
    out_rdy = 1'b0;
    in_vld = 1'b1; in_syn = 7'h00; in_addr = 32'h8000; in_data = ex[0];
    tick();
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL t4_rdy_after_a: got %b expected 1", in_rdy); end
    in_data = ex[1];
    tick();
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("[TB] FAIL t4_rdy_after_b: got %b expected 0", in_rdy); end
    in_data = ex[2];
    tick();
    checks++; if (out_data !== ex[0]) begin errors++; $display("[TB] FAIL t4_hold: got %h expected %h", out_data, ex[0]); end
    out_rdy = 1'b1;
    #1;
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("[TB] FAIL t4_no_comb_rdy: got %b expected 0", in_rdy); end
    for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
      if (out_vld) begin rx[got] = out_data; got++; end
      acc = in_vld & in_rdy;
      tick();
      if (acc) in_vld = 1'b0;
    end
    checks++; if (got !== 3) begin errors++; $display("[TB] FAIL t4_count: got %0d expected 3", got); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rx[i] !== ex[i]) begin errors++; $display("[TB] FAIL t4_order[%0d]: got %h expected %h", i, rx[i], ex[i]); end
    end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL t4_drained: got %b expected 0", out_vld); end
    in_vld = 1'b0;
  endtask

  task automatic test_bypass;
    ecc_en = 1'b0;
    drive_beat(32'h00000001, 7'h07, 32'h6000);
    checks++; if (out_data !== 32'h1) begin errors++; $display("[TB] FAIL t6_bypass_data: got %h expected 1", out_data); end
    checks++; if ({out_ce, out_ue} !== 2'b00) begin errors++; $display("[TB] FAIL t6_bypass_flags: got %b expected 00", {out_ce, out_ue}); end
    tick();
    drive_beat(32'h12345678, 7'h06, 32'h6004);
    checks++; if (out_ue !== 1'b0 || out_data !== 32'h12345678) begin errors++; $display("[TB] FAIL t6_bypass_ue: got %b/%h expected 0/12345678", out_ue, out_data); end
    checks++; if ({ce_cnt, ue_cnt, err_vld} !== 5'b0) begin errors++; $display("[TB] FAIL t6_bypass_stats: got %b expected 0", {ce_cnt, ue_cnt, err_vld}); end
    tick();
    ecc_en = 1'b1;
  endtask

  task automatic test_reset_mid;
    out_rdy = 1'b0;
    drive_beat(32'h00000001, 7'h07, 32'h7000);
    drive_beat(32'h00000010, 7'h06, 32'h7004);
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("[TB] FAIL t6_full: got %b expected 0", in_rdy); end
    checks++; if ({ce_cnt, ue_cnt} !== (STATS ? 4'b0101 : 4'b0)) begin errors++; $display("[TB] FAIL t6_pre_counts: got %b expected %b", {ce_cnt, ue_cnt}, STATS ? 4'b0101 : 4'b0); end
    rstn = 1'b0;
    #2;
    checks++; if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL t6_rst_fifo: got vld %b rdy %b expected 0 1", out_vld, in_rdy); end
    checks++; if ({out_data, out_ce, out_ue} !== 34'h0) begin errors++; $display("[TB] FAIL t6_rst_head: got %h expected 0", {out_data, out_ce, out_ue}); end
    checks++; if ({ce_cnt, ue_cnt, err_vld, err_addr, err_syn} !== 44'h0) begin errors++; $display("[TB] FAIL t6_rst_stats: got %h expected 0", {ce_cnt, ue_cnt, err_vld, err_addr, err_syn}); end
    rstn = 1'b1;
    tick();
    drive_beat(32'h00000001, 7'h07, 32'h7008);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    checks++; if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL t6_swrst_fifo: got vld %b rdy %b expected 0 1", out_vld, in_rdy); end
    checks++; if ({ce_cnt, err_vld} !== 3'b0) begin errors++; $display("[TB] FAIL t6_swrst_stats: got %b expected 0", {ce_cnt, err_vld}); end
    out_rdy = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_ce();
    test_ue();
    test_saturation();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
